// File: rtl/tty_console_seq.sv
// Glass-TTY sequencer: turns an ASCII byte stream into framebuffer cell and
// display-register writes, tracking cursor position and hardware scroll.
module tty_console_seq #(
    parameter int ROWS        = 32,
    parameter int COLS        = 128,
    parameter int CURSOR_VROW = 11
) (
    input  logic        clk_data,
    input  logic        irst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [6:0]  char_attr,
    output logic        char_ready,
    output logic        busy,
    output logic        fb_en,
    output logic [7:0]  fb_we,
    output logic [11:0] fb_addr,
    output logic [63:0] fb_din
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int LW = CW - 2;
    localparam int WW = RW + LW;

    // The state names the write currently presented on the port; WVROW carries
    // the one-off cursor-scanline write issued on leaving INIT.
    typedef enum logic [3:0] {
        INIT, WVROW, IDLE, PUTC, CLRLINE, CLRALL, WSCROLL, WCURX, WCURY
    } state_t;

    typedef struct packed {
        logic [7:0]  we;
        logic [11:0] addr;
        logic [63:0] din;
    } wr_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [RW-1:0] scroll;
    logic [6:0]    attr_q;
    logic [WW-1:0] clr_word;
    wr_t           wr_q;

    logic [RW-1:0] prow;
    logic [CW-1:0] bs_col;
    logic [WW-1:0] clr_next;
    logic [WW-1:0] scroll_line;
    logic          last_row;
    logic          last_col;
    logic          printable;
    logic          known;

    function automatic wr_t reg_wr(input logic [4:0] idx, input logic [15:0] val);
        wr_t w;
        w.we   = 8'hFF;
        w.addr = {1'b1, 6'b0, idx};
        w.din  = {48'b0, val};
        return w;
    endfunction

    function automatic wr_t cell_wr(input logic [RW-1:0] pr, input logic [CW-1:0] c,
                                    input logic [7:0] ch, input logic [6:0] a);
        wr_t w;
        w.we   = 8'b11 << {c[1:0], 1'b0};
        w.addr = 12'({pr, c[CW-1:2]});
        w.din  = 64'({1'b0, a, ch}) << {c[1:0], 4'b0};
        return w;
    endfunction

    function automatic wr_t blank_wr(input logic [WW-1:0] word, input logic [6:0] a);
        wr_t w;
        w.we   = 8'hFF;
        w.addr = 12'(word);
        w.din  = {4{1'b0, a, 8'h20}};
        return w;
    endfunction

    always_comb begin
        prow        = scroll + row;
        bs_col      = (col == '0) ? col : col - 1'b1;
        clr_next    = clr_word + 1'b1;
        scroll_line = {scroll, {LW{1'b0}}};
        last_row    = (row == RW'(ROWS - 1));
        last_col    = (col == CW'(COLS - 1));
        printable   = (char_data >= 8'h20) && (char_data <= 8'h7E);
        known       = printable || (char_data inside {8'h08, 8'h0A, 8'h0C, 8'h0D});
    end

    always_ff @(posedge clk_data) begin
        if (irst) begin
            state      <= INIT;
            col        <= '0;
            row        <= '0;
            scroll     <= '0;
            attr_q     <= '0;
            clr_word   <= '0;
            wr_q       <= '0;
            char_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: every branch below overrides this only when it issues a write,
            // so the port is quiet by default and never holds a stale write.
            wr_q <= '0;
            case (state)
                INIT: begin
                    state <= WVROW;
                    busy  <= 1'b1;
                    wr_q  <= reg_wr(5'd1, 16'(CURSOR_VROW));
                end
                WVROW: begin
                    state <= WCURX;
                    wr_q  <= reg_wr(5'd2, 16'(col));
                end
                IDLE: begin
                    if (char_valid && known) begin
                        char_ready <= 1'b0;
                        busy       <= 1'b1;
                        attr_q     <= char_attr;
                        if (printable) begin
                            state <= PUTC;
                            wr_q  <= cell_wr(prow, col, char_data, char_attr);
                        end else begin
                            case (char_data)
                                8'h0D: begin
                                    col   <= '0;
                                    state <= WCURX;
                                    wr_q  <= reg_wr(5'd2, 16'd0);
                                end
                                8'h08: begin
                                    col   <= bs_col;
                                    state <= WCURX;
                                    wr_q  <= reg_wr(5'd2, 16'(bs_col));
                                end
                                8'h0C: begin
                                    clr_word <= '0;
                                    state    <= CLRALL;
                                    wr_q     <= blank_wr('0, char_attr);
                                end
                                default: begin
                                    if (!last_row) begin
                                        row   <= row + 1'b1;
                                        state <= WCURX;
                                        wr_q  <= reg_wr(5'd2, 16'(col));
                                    end else begin
                                        scroll   <= scroll + 1'b1;
                                        clr_word <= scroll_line;
                                        state    <= CLRLINE;
                                        wr_q     <= blank_wr(scroll_line, char_attr);
                                    end
                                end
                            endcase
                        end
                    end
                end
                PUTC: begin
                    if (!last_col) begin
                        col   <= col + 1'b1;
                        state <= WCURX;
                        wr_q  <= reg_wr(5'd2, 16'(col + 1'b1));
                    end else begin
                        col <= '0;
                        if (!last_row) begin
                            row   <= row + 1'b1;
                            state <= WCURX;
                            wr_q  <= reg_wr(5'd2, 16'd0);
                        end else begin
                            // The line leaving the top becomes the new bottom line.
                            scroll   <= scroll + 1'b1;
                            clr_word <= scroll_line;
                            state    <= CLRLINE;
                            wr_q     <= blank_wr(scroll_line, attr_q);
                        end
                    end
                end
                CLRLINE: begin
                    if (&clr_word[LW-1:0]) begin
                        state <= WSCROLL;
                        wr_q  <= reg_wr(5'd0, 16'(scroll));
                    end else begin
                        clr_word <= clr_next;
                        wr_q     <= blank_wr(clr_next, attr_q);
                    end
                end
                CLRALL: begin
                    if (&clr_word) begin
                        col    <= '0;
                        row    <= '0;
                        scroll <= '0;
                        state  <= WSCROLL;
                        wr_q   <= reg_wr(5'd0, 16'd0);
                    end else begin
                        clr_word <= clr_next;
                        wr_q     <= blank_wr(clr_next, attr_q);
                    end
                end
                WSCROLL: begin
                    state <= WCURX;
                    wr_q  <= reg_wr(5'd2, 16'(col));
                end
                WCURX: begin
                    state <= WCURY;
                    wr_q  <= reg_wr(5'd3, 16'(prow));
                end
                WCURY: begin
                    state      <= IDLE;
                    char_ready <= 1'b1;
                    busy       <= 1'b0;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign fb_en   = |wr_q.we;
    assign fb_we   = wr_q.we;
    assign fb_addr = wr_q.addr;
    assign fb_din  = wr_q.din;

endmodule
